// File: rtl/bsg_nonsynth_dramsim3_unmap.sv
// dramsim3 completion unmapper: global address -> (channel, channel-local address)
// plus one small completion FIFO per channel, drained by that channel's response logic.

package bsg_dramsim3_pkg;

  typedef enum logic [1:0] {
    e_ro_ra_bg_ba_co_ch,
    e_ro_ra_bg_ba_ch_co,
    e_ro_ch_ra_ba_bg_co
  } dram_map_e;

endpackage

module bsg_nonsynth_dramsim3_unmap
  import bsg_dramsim3_pkg::*;
#(
  parameter int channel_addr_width_p = 8,
  parameter int data_width_p = 32,
  parameter int num_channels_p = 2,
  parameter int num_columns_p = 4,
  parameter int num_rows_p = 4,
  parameter int num_ba_p = 2,
  parameter int num_bg_p = 2,
  parameter int num_ranks_p = 1,
  parameter dram_map_e address_mapping_p = e_ro_ra_bg_ba_co_ch,
  parameter int els_p = 4,
  parameter bit debug_p = 1'b0,
  localparam int lg_num_channels_lp = $clog2(num_channels_p),
  localparam int addr_width_lp = lg_num_channels_lp + channel_addr_width_p
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic v_i,
  input  logic [addr_width_lp-1:0] mem_addr_i,
  output logic [num_channels_p-1:0] v_o,
  output logic [num_channels_p-1:0][channel_addr_width_p-1:0] ch_addr_o,
  input  logic [num_channels_p-1:0] yumi_i,
  output logic [num_channels_p-1:0] overflow_o,
  output logic bad_ch_o
);

  localparam int aw_lp = addr_width_lp;
  localparam int bytes_lp = data_width_p >> 3;
  localparam int bo_lp = (bytes_lp <= 1) ? 1 : $clog2(bytes_lp);
  localparam int lg_ch_lp = lg_num_channels_lp;
  localparam int lg_col_lp = $clog2(num_columns_p);
  localparam int lg_row_lp = $clog2(num_rows_p);
  localparam int lg_ba_lp = $clog2(num_ba_p);
  localparam int lg_bg_lp = $clog2(num_bg_p);
  localparam int lg_ra_lp = $clog2(num_ranks_p);
  localparam int ch_w_lp = (lg_ch_lp == 0) ? 1 : lg_ch_lp;
  localparam int ptr_w_lp = (els_p <= 2) ? 1 : $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  // global-space field positions for the row/channel-interleaved map
  localparam int p_col_lp = bo_lp;
  localparam int p_bg_lp = p_col_lp + lg_col_lp;
  localparam int p_ba_lp = p_bg_lp + lg_bg_lp;
  localparam int p_ra_lp = p_ba_lp + lg_ba_lp;
  localparam int p_ch_lp = p_ra_lp + lg_ra_lp;
  localparam int p_row_lp = p_ch_lp + lg_ch_lp;

  // channel-space positions: ba and bg trade places
  localparam int q_ba_lp = bo_lp + lg_col_lp;
  localparam int q_bg_lp = q_ba_lp + lg_ba_lp;
  localparam int q_ra_lp = q_bg_lp + lg_bg_lp;
  localparam int q_row_lp = q_ra_lp + lg_ra_lp;

  function automatic logic [aw_lp-1:0] mask(input int w);
    if (w <= 0) return '0;
    return {aw_lp{1'b1}} >> (aw_lp - w);
  endfunction

  localparam logic [aw_lp-1:0] ch_m_lp = mask(lg_ch_lp);
  localparam logic [aw_lp-1:0] col_m_lp = mask(lg_col_lp);
  localparam logic [aw_lp-1:0] row_m_lp = mask(lg_row_lp);
  localparam logic [aw_lp-1:0] ba_m_lp = mask(lg_ba_lp);
  localparam logic [aw_lp-1:0] bg_m_lp = mask(lg_bg_lp);
  localparam logic [aw_lp-1:0] ra_m_lp = mask(lg_ra_lp);

  logic [ch_w_lp-1:0] ch_idx;
  logic [channel_addr_width_p-1:0] ca;
  logic [aw_lp-1:0] col_f, row_f, ba_f, bg_f, ra_f;
  logic ch_ok;

  // combinational address decode; byte-offset bits of ca always zero
  always_comb begin
    col_f = '0;
    row_f = '0;
    ba_f = '0;
    bg_f = '0;
    ra_f = '0;
    ch_idx = '0;
    ca = '0;
    case (address_mapping_p)
      e_ro_ra_bg_ba_ch_co: begin
        ch_idx = ch_w_lp'(
          (mem_addr_i >> (bo_lp + lg_col_lp)) & ch_m_lp);
        ca = channel_addr_width_p'(
          ((mem_addr_i >> (bo_lp + lg_col_lp + lg_ch_lp))
            << (bo_lp + lg_col_lp))
          | (mem_addr_i & (col_m_lp << bo_lp)));
      end
      e_ro_ch_ra_ba_bg_co: begin
        col_f = (mem_addr_i >> p_col_lp) & col_m_lp;
        bg_f = (mem_addr_i >> p_bg_lp) & bg_m_lp;
        ba_f = (mem_addr_i >> p_ba_lp) & ba_m_lp;
        ra_f = (mem_addr_i >> p_ra_lp) & ra_m_lp;
        row_f = (mem_addr_i >> p_row_lp) & row_m_lp;
        ch_idx = ch_w_lp'(
          (mem_addr_i >> p_ch_lp) & ch_m_lp);
        ca = channel_addr_width_p'(
          (col_f << bo_lp)
          | (ba_f << q_ba_lp)
          | (bg_f << q_bg_lp)
          | (ra_f << q_ra_lp)
          | (row_f << q_row_lp));
      end
      default: begin
        ch_idx = ch_w_lp'(
          (mem_addr_i >> bo_lp) & ch_m_lp);
        ca = channel_addr_width_p'(
          (mem_addr_i >> (bo_lp + lg_ch_lp)) << bo_lp);
      end
    endcase
    ch_ok = 32'(ch_idx) < 32'(num_channels_p);
  end

  // sticky flag for completions that decode to a nonexistent channel
  always_ff @(posedge clk_i) begin
    if (reset_i) bad_ch_o <= 1'b0;
    else if (v_i & ~ch_ok) bad_ch_o <= 1'b1;
  end

  for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
    logic [channel_addr_width_p-1:0] mem_r [els_p];
    logic [ptr_w_lp-1:0] rd_r, wr_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic ov_r;
    logic enq, deq, full, wr_en;

    assign enq = v_i & ch_ok & (32'(ch_idx) == c);
    assign deq = yumi_i[c] & (cnt_r != '0);
    assign full = cnt_r == cnt_w_lp'(els_p);
    assign wr_en = enq & (~full | deq);

    assign v_o[c] = cnt_r != '0;
    assign ch_addr_o[c] = mem_r[rd_r];
    assign overflow_o[c] = ov_r;

    // entry storage, written at the tail
    always_ff @(posedge clk_i) begin
      if (wr_en) mem_r[wr_r] <= ca;
    end

    // pointers, occupancy and sticky overflow
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        rd_r <= '0;
        wr_r <= '0;
        cnt_r <= '0;
        ov_r <= 1'b0;
      end else begin
        if (wr_en)
          wr_r <= (wr_r == ptr_w_lp'(els_p - 1))
            ? '0 : wr_r + ptr_w_lp'(1);
        if (deq)
          rd_r <= (rd_r == ptr_w_lp'(els_p - 1))
            ? '0 : rd_r + ptr_w_lp'(1);
        if (wr_en & ~deq) cnt_r <= cnt_r + cnt_w_lp'(1);
        else if (deq & ~wr_en) cnt_r <= cnt_r - cnt_w_lp'(1);
        if (enq & ~wr_en) ov_r <= 1'b1;
      end
    end

    // protocol checks on the dequeue side and drop reporting
    always_ff @(posedge clk_i) begin
      if (!reset_i) begin
        assert (!(yumi_i[c] && cnt_r == '0))
          else $error("yumi on empty channel %0d", c);
        if (debug_p && enq && !wr_en)
          $error("completion dropped on channel %0d", c);
      end
    end
  end

endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_unmap.sv
// Bench for the dramsim3 unmapper: four configurations, directed cases
// then random forward-mapped traffic checked against queue models.

module tb_bsg_nonsynth_dramsim3_unmap;
  import bsg_dramsim3_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic tv [4];
  logic [9:0] ta [4];
  logic [2:0] ty [4];

  logic v0, v1, v2, v3;
  logic [8:0] a0, a1, a2;
  logic [9:0] a3;
  logic [1:0] y0, y1, y2;
  logic [2:0] y3;
  logic [1:0] vo0, vo1, vo2, ov0, ov1, ov2;
  logic [2:0] vo3, ov3;
  logic [1:0][7:0] c0, c1, c2;
  logic [2:0][7:0] c3;
  logic bad0, bad1, bad2, bad3;

  assign v0 = tv[0];
  assign v1 = tv[1];
  assign v2 = tv[2];
  assign v3 = tv[3];
  assign a0 = ta[0][8:0];
  assign a1 = ta[1][8:0];
  assign a2 = ta[2][8:0];
  assign a3 = ta[3];
  assign y0 = ty[0][1:0];
  assign y1 = ty[1][1:0];
  assign y2 = ty[2][1:0];
  assign y3 = ty[3];

  bsg_nonsynth_dramsim3_unmap #(
    .channel_addr_width_p(8), .data_width_p(32), .num_channels_p(2),
    .num_columns_p(4), .num_rows_p(4), .num_ba_p(2), .num_bg_p(2),
    .num_ranks_p(1), .address_mapping_p(e_ro_ra_bg_ba_co_ch),
    .els_p(4), .debug_p(1'b0)
  ) u0 (
    .clk_i(clk), .reset_i(rst), .v_i(v0), .mem_addr_i(a0),
    .v_o(vo0), .ch_addr_o(c0), .yumi_i(y0),
    .overflow_o(ov0), .bad_ch_o(bad0)
  );

  bsg_nonsynth_dramsim3_unmap #(
    .channel_addr_width_p(8), .data_width_p(32), .num_channels_p(2),
    .num_columns_p(4), .num_rows_p(4), .num_ba_p(2), .num_bg_p(2),
    .num_ranks_p(1), .address_mapping_p(e_ro_ra_bg_ba_ch_co),
    .els_p(4), .debug_p(1'b0)
  ) u1 (
    .clk_i(clk), .reset_i(rst), .v_i(v1), .mem_addr_i(a1),
    .v_o(vo1), .ch_addr_o(c1), .yumi_i(y1),
    .overflow_o(ov1), .bad_ch_o(bad1)
  );

  bsg_nonsynth_dramsim3_unmap #(
    .channel_addr_width_p(8), .data_width_p(32), .num_channels_p(2),
    .num_columns_p(4), .num_rows_p(4), .num_ba_p(2), .num_bg_p(2),
    .num_ranks_p(1), .address_mapping_p(e_ro_ch_ra_ba_bg_co),
    .els_p(4), .debug_p(1'b0)
  ) u2 (
    .clk_i(clk), .reset_i(rst), .v_i(v2), .mem_addr_i(a2),
    .v_o(vo2), .ch_addr_o(c2), .yumi_i(y2),
    .overflow_o(ov2), .bad_ch_o(bad2)
  );

  bsg_nonsynth_dramsim3_unmap #(
    .channel_addr_width_p(8), .data_width_p(32), .num_channels_p(3),
    .num_columns_p(4), .num_rows_p(4), .num_ba_p(2), .num_bg_p(2),
    .num_ranks_p(1), .address_mapping_p(e_ro_ra_bg_ba_co_ch),
    .els_p(4), .debug_p(1'b0)
  ) u3 (
    .clk_i(clk), .reset_i(rst), .v_i(v3), .mem_addr_i(a3),
    .v_o(vo3), .ch_addr_o(c3), .yumi_i(y3),
    .overflow_o(ov3), .bad_ch_o(bad3)
  );

  int checks = 0;
  int errors = 0;
  bit auto_y = 1'b0;

  int nch [4] = '{2, 2, 2, 3};
  logic [7:0] mq [12][$];
  logic [2:0] mov [4];
  logic mbad [4];
  int pch [4];
  logic [7:0] pca [4];

  function automatic logic [2:0] get_vo(int i);
    case (i)
      0: return {1'b0, vo0};
      1: return {1'b0, vo1};
      2: return {1'b0, vo2};
      default: return vo3;
    endcase
  endfunction

  function automatic logic [2:0] get_ov(int i);
    case (i)
      0: return {1'b0, ov0};
      1: return {1'b0, ov1};
      2: return {1'b0, ov2};
      default: return ov3;
    endcase
  endfunction

  function automatic logic get_bad(int i);
    case (i)
      0: return bad0;
      1: return bad1;
      2: return bad2;
      default: return bad3;
    endcase
  endfunction

  function automatic logic [7:0] get_ca(int i, int c);
    case (i)
      0: return c0[c];
      1: return c1[c];
      2: return c2[c];
      default: return c3[c];
    endcase
  endfunction

  // global address built from channel-space fields with plain arithmetic
  function automatic logic [9:0] fwd(int i, int ch, int ca);
    int col, ba, bg, row, m;
    col = (ca / 4) % 4;
    case (i)
      0: m = ((ca / 4) * 2 + ch) * 4;
      1: m = (((ca / 16) * 2 + ch) * 4 + col) * 4;
      2: begin
        ba = (ca / 16) % 2;
        bg = (ca / 32) % 2;
        row = ca / 64;
        m = ((((row * 2 + ch) * 2 + ba) * 2 + bg) * 4 + col) * 4;
      end
      default: m = ((ca / 4) * 4 + ch) * 4;
    endcase
    return 10'(m);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(int i, logic [9:0] m, int ch, logic [7:0] ca);
    tv[i] = 1'b1;
    ta[i] = m;
    pch[i] = ch;
    pca[i] = ca;
  endtask

  task automatic check_all();
    logic [2:0] vo, ov;
    for (int i = 0; i < 4; i++) begin
      vo = get_vo(i);
      ov = get_ov(i);
      for (int c = 0; c < nch[i]; c++) begin
        chk($sformatf("v_o u%0d c%0d", i, c),
          32'(vo[c]), 32'(mq[i*3+c].size() > 0));
        if (mq[i*3+c].size() > 0)
          chk($sformatf("ch_addr u%0d c%0d", i, c),
            32'(get_ca(i, c)), 32'(mq[i*3+c][0]));
        chk($sformatf("overflow u%0d c%0d", i, c),
          32'(ov[c]), 32'(mov[i][c]));
      end
      chk($sformatf("bad_ch u%0d", i),
        32'(get_bad(i)), 32'(mbad[i]));
    end
  endtask

  task automatic tick();
    int q;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        for (int c = 0; c < 3; c++) mq[i*3+c].delete();
        mov[i] = '0;
        mbad[i] = 1'b0;
      end else begin
        for (int c = 0; c < nch[i]; c++)
          if (ty[i][c] && mq[i*3+c].size() > 0)
            void'(mq[i*3+c].pop_front());
        if (tv[i]) begin
          q = i * 3 + pch[i];
          if (pch[i] >= nch[i]) mbad[i] = 1'b1;
          else if (mq[q].size() < 4) mq[q].push_back(pca[i]);
          else mov[i][pch[i]] = 1'b1;
        end
      end
    end
    @(negedge clk);
    check_all();
    for (int i = 0; i < 4; i++) begin
      tv[i] = 1'b0;
      ty[i] = '0;
      if (auto_y)
        for (int c = 0; c < nch[i]; c++)
          ty[i][c] = (mq[i*3+c].size() > 0) && ($urandom % 2 == 1);
    end
  endtask

  initial begin
    int i, ch, ca;
    for (int k = 0; k < 4; k++) begin
      tv[k] = 1'b0;
      ta[k] = '0;
      ty[k] = '0;
      mov[k] = '0;
      mbad[k] = 1'b0;
      pch[k] = 0;
      pca[k] = '0;
    end

    rst = 1'b1;
    send(0, 10'h014, 1, 8'h08);
    tick();
    tick();
    rst = 1'b0;

    send(0, 10'h014, 1, 8'h08);
    tick();
    ty[0] = 3'b010;
    tick();

    send(1, 10'h03C, 1, 8'h1C);
    tick();
    ty[1] = 3'b010;
    tick();

    send(2, 10'h158, 1, 8'hA8);
    tick();
    ty[2] = 3'b010;
    tick();

    for (int k = 0; k < 5; k++) begin
      send(0, 10'(k * 8), 0, 8'(k * 4));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      ty[0] = 3'b001;
      tick();
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(0, 10'(k * 8), 0, 8'(k * 4));
      if (k == 4) ty[0] = 3'b001;
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      ty[0] = 3'b001;
      tick();
    end

    send(3, 10'h00C, 3, 8'h00);
    tick();
    send(3, 10'h008, 2, 8'h00);
    tick();
    ty[3] = 3'b100;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    auto_y = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom % 4 != 0) begin
        i = int'($urandom % 4);
        ch = (i == 3) ? int'($urandom % 4) : int'($urandom % 2);
        ca = int'($urandom % 64) * 4;
        send(i, fwd(i, ch, ca) + 10'($urandom % 4), ch, 8'(ca));
      end
      tick();
    end

    auto_y = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ca = int'($urandom % 64) * 4;
      send(2, fwd(2, 0, ca), 0, 8'(ca));
      tick();
    end
    chk("queued three", 32'(mq[6].size()), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
